trace_commit_buffer: RTL and testbench

TRACE_COMMIT_BUFFER -- requirements
Module: trace_commit_buffer

---
 rtl/trace_pkg.sv | 68 ++++++
 rtl/trace_commit_buffer_if.sv | 48 ++++
 rtl/trace_fifo_2w1r.sv | 60 ++++++
 rtl/trace_commit_buffer.sv | 117 +++++++++++
 tb/tb_trace_commit_buffer.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/trace_pkg.sv
// Shared types for the trace commit buffer.
//   trace_entry_t : retire payload presented on each commit port.
//   store_t       : subset of trace_entry_t actually kept in the FIFO.
//                   The FPU fields are present only with TRACE_FPU_FLAGS_EN.
//   trc_state_t   : output sequencer states, also exported for debug.
//   MEM_*         : mem_size encodings.
// Optional feature macro: TRACE_FPU_FLAGS_EN.
package trace_pkg;

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  reg_addr;
    logic [31:0] reg_data;
    logic        is_load;
    logic        is_store;
    logic        is_float;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic [4:0]  fflags;
  } trace_entry_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  reg_addr;
    logic [31:0] reg_data;
    logic        is_load;
    logic        is_store;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
`ifdef TRACE_FPU_FLAGS_EN
    logic        is_float;
    logic [4:0]  fflags;
`endif
  } store_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } trc_state_t;

  function automatic store_t to_store(input trace_entry_t e);
    store_t s;
    s.pc       = e.pc;
    s.instr    = e.instr;
    s.reg_addr = e.reg_addr;
    s.reg_data = e.reg_data;
    s.is_load  = e.is_load;
    s.is_store = e.is_store;
    s.mem_size = e.mem_size;
    s.mem_addr = e.mem_addr;
    s.mem_data = e.mem_data;
`ifdef TRACE_FPU_FLAGS_EN
    s.is_float = e.is_float;
    s.fflags   = e.fflags;
`endif
    return s;
  endfunction

endpackage

// File: rtl/trace_commit_buffer_if.sv
// Bundle of commit-side and trace-side signals of trace_commit_buffer.
// Handshake: a commit on port N is taken on a rising edge where
// commitN_valid_i=1 and commit_ready_o=1. When commit_ready_o=0 the commit
// is not stalled but discarded and counted in drop_cnt_o. trc_valid_o is a
// one-cycle strobe with no back-pressure; trc_* data stays stable until
// the next strobe.
//   master : retire side (drives commits, observes trace outputs)
//   slave  : trace_commit_buffer
interface trace_commit_buffer_if;
  import trace_pkg::*;

  logic         commit0_valid_i;
  logic         commit1_valid_i;
  trace_entry_t commit0_i;
  trace_entry_t commit1_i;
  logic         commit_ready_o;
  logic         trc_valid_o;
  logic [31:0]  trc_pc_o;
  logic [31:0]  trc_instr_o;
  logic [4:0]   trc_reg_addr_o;
  logic [31:0]  trc_reg_data_o;
  logic         trc_is_load_o;
  logic         trc_is_store_o;
  logic         trc_is_float_o;
  logic [1:0]   trc_mem_size_o;
  logic [31:0]  trc_mem_addr_o;
  logic [31:0]  trc_mem_data_o;
  logic [31:0]  trc_fpu_flags_o;
  logic [15:0]  drop_cnt_o;
  trc_state_t   dbg_state_o;

  modport master (
    output commit0_valid_i, commit1_valid_i, commit0_i, commit1_i,
    input  commit_ready_o, trc_valid_o, trc_pc_o, trc_instr_o, trc_reg_addr_o,
           trc_reg_data_o, trc_is_load_o, trc_is_store_o, trc_is_float_o,
           trc_mem_size_o, trc_mem_addr_o, trc_mem_data_o, trc_fpu_flags_o,
           drop_cnt_o, dbg_state_o
  );

  modport slave (
    input  commit0_valid_i, commit1_valid_i, commit0_i, commit1_i,
    output commit_ready_o, trc_valid_o, trc_pc_o, trc_instr_o, trc_reg_addr_o,
           trc_reg_data_o, trc_is_load_o, trc_is_store_o, trc_is_float_o,
           trc_mem_size_o, trc_mem_addr_o, trc_mem_data_o, trc_fpu_flags_o,
           drop_cnt_o, dbg_state_o
  );

endinterface

// File: rtl/trace_fifo_2w1r.sv
// Two-write / one-read FIFO storage for trace entries.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_cnt      : number of entries written this edge (0..2); wdata0 goes
//                   first, wdata1 second
//   pop           : remove head this edge (ignored when empty)
//   head          : entry at the read pointer
//   empty, ready  : ready is high while at least 2 entries are free
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module trace_fifo_2w1r
  import trace_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] push_cnt,
  input  store_t     wdata0,
  input  store_t     wdata1,
  input  logic       pop,
  output store_t     head,
  output logic       empty,
  output logic       ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] wptr_q, rptr_q;
  logic [PW-1:0] occ;
  logic [AW-1:0] waddr0, waddr1;
  logic          full;
  logic          do_pop;
  store_t        mem [DEPTH];

  assign occ    = wptr_q - rptr_q;
  assign empty  = (wptr_q == rptr_q);
  assign full   = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign ready  = !full && (occ <= PW'(DEPTH - 2));
  assign do_pop = pop && !empty;
  assign waddr0 = wptr_q[AW-1:0];
  assign waddr1 = waddr0 + AW'(1);
  assign head   = mem[rptr_q[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_q + PW'(push_cnt);
      rptr_q <= rptr_q + PW'(do_pop);
    end
  end

  // Storage needs no reset: entries are only read behind the write pointer.
  always_ff @(posedge clk_i) begin
    if (push_cnt != 2'd0) mem[waddr0] <= wdata0;
    if (push_cnt == 2'd2) mem[waddr1] <= wdata1;
  end

endmodule

// File: rtl/trace_commit_buffer.sv
// Trace commit buffer: collects up to two retire events per cycle into a
// FIFO and replays them to a trace logger as one-cycle strobes, at most one
// every two cycles (IDLE/PULSE/GAP sequencer). Commits arriving while fewer
// than two entries are free are dropped and counted (saturating).
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   io            : trace_commit_buffer_if.slave (commit ports, trace
//                   outputs, drop counter, debug state)
// Optional feature macro: TRACE_FPU_FLAGS_EN (store/forward is_float, fflags).
module trace_commit_buffer
  import trace_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input logic                  clk_i,
  input logic                  rst_ni,
  trace_commit_buffer_if.slave io
);

  logic       ready, empty, pop, valid_q;
  logic [1:0] push_cnt;
  store_t     wdata0, wdata1, head, out_q;
  trc_state_t state_q;
  logic [15:0] drop_q, drop_next;
  logic [16:0] drop_sum;

  trace_fifo_2w1r #(.DEPTH(DEPTH)) u_fifo (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .push_cnt (push_cnt),
    .wdata0   (wdata0),
    .wdata1   (wdata1),
    .pop      (pop),
    .head     (head),
    .empty    (empty),
    .ready    (ready)
  );

  // Compact the valid commits so a lone port-1 commit lands in slot 0.
  always_comb begin
    push_cnt = 2'd0;
    wdata0   = to_store(io.commit0_i);
    wdata1   = to_store(io.commit1_i);
    if (ready) begin
      case ({io.commit1_valid_i, io.commit0_valid_i})
        2'b01:   push_cnt = 2'd1;
        2'b10: begin
          push_cnt = 2'd1;
          wdata0   = to_store(io.commit1_i);
        end
        2'b11:   push_cnt = 2'd2;
        default: push_cnt = 2'd0;
      endcase
    end
  end

  always_comb begin
    drop_sum  = {1'b0, drop_q} + 17'(io.commit0_valid_i) + 17'(io.commit1_valid_i);
    drop_next = drop_q;
    if (!ready) drop_next = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  // A pop happens exactly on each transition into PULSE.
  assign pop = !empty && (state_q != ST_PULSE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      out_q   <= '0;
      drop_q  <= '0;
    end else begin
      drop_q <= drop_next;
      case (state_q)
        ST_IDLE, ST_GAP: begin
          if (!empty) begin
            state_q <= ST_PULSE;
            valid_q <= 1'b1;
            out_q   <= head;
          end else begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
          end
        end
        ST_PULSE: begin
          state_q <= ST_GAP;
          valid_q <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign io.commit_ready_o = ready;
  assign io.drop_cnt_o     = drop_q;
  assign io.dbg_state_o    = state_q;
  assign io.trc_valid_o    = valid_q;
  assign io.trc_pc_o       = out_q.pc;
  assign io.trc_instr_o    = out_q.instr;
  assign io.trc_reg_addr_o = out_q.reg_addr;
  assign io.trc_reg_data_o = out_q.reg_data;
  assign io.trc_is_load_o  = out_q.is_load;
  assign io.trc_is_store_o = out_q.is_store;
  assign io.trc_mem_size_o = out_q.mem_size;
  assign io.trc_mem_addr_o = out_q.mem_addr;
  assign io.trc_mem_data_o = out_q.mem_data;
`ifdef TRACE_FPU_FLAGS_EN
  assign io.trc_is_float_o  = out_q.is_float;
  assign io.trc_fpu_flags_o = {27'd0, out_q.fflags};
`else
  assign io.trc_is_float_o  = 1'b0;
  assign io.trc_fpu_flags_o = 32'd0;
`endif

endmodule

// File: tb/tb_trace_commit_buffer.sv
// Directed testbench for trace_commit_buffer (DEPTH=8).
module tb_trace_commit_buffer;
  import trace_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;
  logic prev_valid = 1'b0;
  logic [31:0] exp_q[$];
  trace_entry_t e0, e1;

  trace_commit_buffer_if io ();

  trace_commit_buffer #(.DEPTH(8)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .io     (io)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic trace_entry_t mk(input logic [31:0] pc, input logic [4:0] ra,
                                      input logic [31:0] rd);
    trace_entry_t e;
    e = '0;
    e.pc = pc;
    e.instr = pc ^ 32'h0000_0013;
    e.reg_addr = ra;
    e.reg_data = rd;
    return e;
  endfunction

  task automatic drive(input logic v0, input trace_entry_t c0, input logic v1,
                       input trace_entry_t c1);
    io.commit0_valid_i = v0;
    io.commit0_i = c0;
    io.commit1_valid_i = v1;
    io.commit1_i = c1;
  endtask

  task automatic idle_in();
    drive(1'b0, '0, 1'b0, '0);
  endtask

  // One clock; inputs set before the call are sampled at its rising edge.
  // Outputs are examined at the following falling edge, where every strobe
  // is matched against the expected-PC queue.
  task automatic tick();
    logic [31:0] exp;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    assert (!(io.trc_valid_o && prev_valid)) else begin
      n_fail++;
      $error("FAIL strobe_gap: observed two consecutive high cycles, required a low cycle");
    end
    if (io.trc_valid_o) begin
      n_cmp++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_strobe: observed pc 0x%0h, required no strobe", io.trc_pc_o);
      end
      if (exp_q.size() != 0) begin
        exp = exp_q.pop_front();
        chk("strobe_pc", io.trc_pc_o, exp);
      end
    end
    prev_valid = io.trc_valid_o;
  endtask

  initial begin
    idle_in();

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(io.trc_valid_o), 32'd0);
    chk("rst_pc", io.trc_pc_o, 32'd0);
    chk("rst_drop", 32'(io.drop_cnt_o), 32'd0);
    chk("rst_state", 32'(io.dbg_state_o), 32'(ST_IDLE));
    rst_n = 1'b1;
    tick();
    chk("rst_ready", 32'(io.commit_ready_o), 32'd1);

    // Single commit: strobe two edges after capture, then data held
    drive(1'b1, mk(32'h8000_0000, 5'd5, 32'h12), 1'b0, '0);
    exp_q.push_back(32'h8000_0000);
    tick();
    idle_in();
    chk("t1_valid_e0", 32'(io.trc_valid_o), 32'd0);
    tick();
    chk("t1_valid_e1", 32'(io.trc_valid_o), 32'd1);
    chk("t1_pc", io.trc_pc_o, 32'h8000_0000);
    chk("t1_reg_addr", 32'(io.trc_reg_addr_o), 32'd5);
    chk("t1_reg_data", io.trc_reg_data_o, 32'h12);
    tick();
    chk("t1_valid_e2", 32'(io.trc_valid_o), 32'd0);
    chk("t1_pc_hold", io.trc_pc_o, 32'h8000_0000);
    tick();
    chk("t1_state_idle", 32'(io.dbg_state_o), 32'(ST_IDLE));

    // Dual commit: 0x100 then 0x104 with exactly one low cycle between
    drive(1'b1, mk(32'h100, 5'd1, 32'h1), 1'b1, mk(32'h104, 5'd2, 32'h2));
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    tick();
    idle_in();
    chk("t2_valid_e0", 32'(io.trc_valid_o), 32'd0);
    tick();
    chk("t2_valid_e1", 32'(io.trc_valid_o), 32'd1);
    chk("t2_pc0", io.trc_pc_o, 32'h100);
    tick();
    chk("t2_valid_e2", 32'(io.trc_valid_o), 32'd0);
    tick();
    chk("t2_valid_e3", 32'(io.trc_valid_o), 32'd1);
    chk("t2_pc1", io.trc_pc_o, 32'h104);
    tick();
    chk("t2_valid_e4", 32'(io.trc_valid_o), 32'd0);
    tick();

    // Store event with FPU fields driven
    e0 = mk(32'h400, 5'd0, 32'h0);
    e0.instr = 32'h00A1_1023;
    e0.is_store = 1'b1;
    e0.mem_size = MEM_HALF;
    e0.mem_addr = 32'h2000;
    e0.mem_data = 32'hBEEF;
    e0.is_float = 1'b1;
    e0.fflags = 5'h1F;
    drive(1'b1, e0, 1'b0, '0);
    exp_q.push_back(32'h400);
    tick();
    idle_in();
    tick();
    chk("t5_valid", 32'(io.trc_valid_o), 32'd1);
    chk("t5_instr", io.trc_instr_o, 32'h00A1_1023);
    chk("t5_is_store", 32'(io.trc_is_store_o), 32'd1);
    chk("t5_is_load", 32'(io.trc_is_load_o), 32'd0);
    chk("t5_mem_size", 32'(io.trc_mem_size_o), 32'd1);
    chk("t5_mem_addr", io.trc_mem_addr_o, 32'h2000);
    chk("t5_mem_data", io.trc_mem_data_o, 32'hBEEF);
`ifdef TRACE_FPU_FLAGS_EN
    chk("t5_is_float", 32'(io.trc_is_float_o), 32'd1);
    chk("t5_fflags", io.trc_fpu_flags_o, 32'h1F);
`else
    chk("t5_is_float", 32'(io.trc_is_float_o), 32'd0);
    chk("t5_fflags", io.trc_fpu_flags_o, 32'd0);
`endif
    tick();
    tick();

    // Lone commit on port 1
    drive(1'b0, '0, 1'b1, mk(32'h500, 5'd7, 32'h77));
    exp_q.push_back(32'h500);
    tick();
    idle_in();
    tick();
    chk("lone1_valid", 32'(io.trc_valid_o), 32'd1);
    chk("lone1_reg_data", io.trc_reg_data_o, 32'h77);
    tick();
    tick();

    // Overflow: 5 back-to-back dual commits fill to 8, then drops
    for (int i = 0; i < 5; i++) begin
      chk("t3_ready_fill", 32'(io.commit_ready_o), 32'd1);
      drive(1'b1, mk(32'h200 + 32'(8 * i), 5'd3, 32'(i)),
            1'b1, mk(32'h204 + 32'(8 * i), 5'd4, 32'(i)));
      exp_q.push_back(32'h200 + 32'(8 * i));
      exp_q.push_back(32'h204 + 32'(8 * i));
      tick();
    end
    chk("t3_ready_full", 32'(io.commit_ready_o), 32'd0);
    chk("t3_drop_none", 32'(io.drop_cnt_o), 32'd0);
    drive(1'b1, mk(32'h300, 5'd0, 32'h0), 1'b1, mk(32'h304, 5'd0, 32'h0));
    tick();
    chk("t3_drop_dual", 32'(io.drop_cnt_o), 32'd2);
    chk("t3_ready_occ7", 32'(io.commit_ready_o), 32'd0);
    drive(1'b0, '0, 1'b1, mk(32'h308, 5'd0, 32'h0));
    tick();
    idle_in();
    chk("t3_drop_lone", 32'(io.drop_cnt_o), 32'd3);
    for (int i = 0; i < 24; i++) tick();
    chk("t3_all_drained", 32'(exp_q.size()), 32'd0);
    chk("t3_ready_after", 32'(io.commit_ready_o), 32'd1);
    chk("t3_drop_final", 32'(io.drop_cnt_o), 32'd3);

    // Reset mid-stream: buffered entries vanish, drop counter clears
    drive(1'b1, mk(32'h600, 5'd1, 32'h0), 1'b1, mk(32'h604, 5'd1, 32'h0));
    exp_q.push_back(32'h600);
    tick();
    drive(1'b1, mk(32'h608, 5'd1, 32'h0), 1'b1, mk(32'h60C, 5'd1, 32'h0));
    tick();
    idle_in();
    chk("t4_valid_pre", 32'(io.trc_valid_o), 32'd1);
    chk("t4_drop_pre", 32'(io.drop_cnt_o), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("t4_valid_rst", 32'(io.trc_valid_o), 32'd0);
    chk("t4_pc_rst", io.trc_pc_o, 32'd0);
    chk("t4_drop_rst", 32'(io.drop_cnt_o), 32'd0);
    exp_q.delete();
    prev_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("t4_drop_after", 32'(io.drop_cnt_o), 32'd0);
    chk("t4_ready_after", 32'(io.commit_ready_o), 32'd1);
    chk("t4_state_after", 32'(io.dbg_state_o), 32'(ST_IDLE));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
